// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Stalls on load-use, flushes on redirects, and freezes the pipeline during data-memory accesses.
module pipe_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_to_reg,
    input  logic [4:0]       ex_write_reg,
    input  logic             mem_branch_taken,
    input  logic             mem_jump,
    input  logic             mem_access,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic redirect;

    assign lu = ex_mem_to_reg && (ex_write_reg != 5'd0) &&
                ((ex_write_reg == id_rs) ||
                 (id_uses_rt && (ex_write_reg == id_rt)));

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        dmem_req      = 1'b0;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;
        pc_sel        = 2'b00;
        redirect      = 1'b0;

        if (clr) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_access) begin
                        dmem_req    = 1'b1;
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        state_d     = MEM_WAIT;
                        wait_cnt_d  = 8'd1;
                    end else if (mem_jump || mem_branch_taken) begin
                        // The load-use victim sits in ID and is flushed here.
                        redirect    = 1'b1;
                        pc_sel      = mem_jump ? 2'b10 : 2'b01;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (lu) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_d    = RUN;
                        wait_cnt_d = 8'd0;
                    end else if (wait_cnt_q >= WAIT_LIM) begin
                        mem_timeout_d = 1'b1;
                        state_d       = RUN;
                        wait_cnt_d    = 8'd0;
                    end else begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        wait_cnt_d  = wait_cnt_q + 8'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        flush_cnt_d = flush_cnt_q;
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign busy        = !clr && (state_q == MEM_WAIT);
    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with WAIT_MAX=4 and CNT_W=4.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] id_rs, id_rt, ex_write_reg;
    logic       id_uses_rt, ex_mem_to_reg;
    logic       mem_branch_taken, mem_jump, mem_access, dmem_ack;
    logic       dmem_req, pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0] pc_sel;
    logic       busy, mem_timeout;
    logic [3:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // {pc,ifid,idex,exmem en | ifid,idex,exmem,memwb flush | pc_sel | req | busy}
    localparam logic [11:0] C_RST  = 12'b0000_1111_00_0_0;
    localparam logic [11:0] C_RUN  = 12'b1111_0000_00_0_0;
    localparam logic [11:0] C_STL  = 12'b0011_0100_00_0_0;
    localparam logic [11:0] C_BR   = 12'b1111_1110_01_0_0;
    localparam logic [11:0] C_JMP  = 12'b1111_1110_10_0_0;
    localparam logic [11:0] C_REQ  = 12'b0000_0001_00_1_0;
    localparam logic [11:0] C_WAIT = 12'b0000_0001_00_0_1;
    localparam logic [11:0] C_ADV  = 12'b1111_0000_00_0_1;

    pipe_ctrl #(.WAIT_MAX(4), .CNT_W(4)) dut (
        .clk(clk), .clr(clr),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
        .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
        .mem_access(mem_access), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .pc_sel(pc_sel), .busy(busy), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ctrl();
        return {pc_en, ifid_en, idex_en, exmem_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush,
                pc_sel, dmem_req, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_mem_to_reg = 0; ex_write_reg = 0;
        mem_branch_taken = 0; mem_jump = 0;
        mem_access = 0; dmem_ack = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        clr = 1'b1;
        idle();
        cyc(); #1;
        chk("reset_ctrl", 32'(ctrl()), 32'(C_RST));
        cyc(); clr = 1'b0; #1;
        chk("idle_ctrl", 32'(ctrl()), 32'(C_RUN));
        chk("idle_stall", 32'(stall_cnt), 0);
        chk("idle_flush", 32'(flush_cnt), 0);
        chk("idle_tmo", 32'(mem_timeout), 0);

        // load-use on rs
        cyc(); ex_mem_to_reg = 1; ex_write_reg = 5; id_rs = 5; #1;
        chk("lu_rs", 32'(ctrl()), 32'(C_STL));
        cyc(); idle(); #1;
        chk("lu_after", 32'(ctrl()), 32'(C_RUN));
        chk("lu_cnt1", 32'(stall_cnt), 1);
        // destination r0 never hazards
        cyc(); ex_mem_to_reg = 1; ex_write_reg = 0; id_rs = 0; #1;
        chk("lu_r0", 32'(ctrl()), 32'(C_RUN));
        // rt match only counts when rt is read
        cyc(); ex_mem_to_reg = 1; ex_write_reg = 7; id_rt = 7; id_rs = 1; #1;
        chk("lu_rt_unused", 32'(ctrl()), 32'(C_RUN));
        cyc(); id_uses_rt = 1; #1;
        chk("lu_rt", 32'(ctrl()), 32'(C_STL));
        // branch beats load-use
        cyc(); mem_branch_taken = 1; #1;
        chk("br_lu", 32'(ctrl()), 32'(C_BR));
        cyc(); mem_jump = 1; #1;
        chk("jmp_br", 32'(ctrl()), 32'(C_JMP));
        cyc(); idle(); dmem_ack = 1; #1;
        chk("ack_in_run", 32'(ctrl()), 32'(C_RUN));
        chk("br_stall", 32'(stall_cnt), 2);
        chk("br_flush", 32'(flush_cnt), 2);

        // access acked on MEM_WAIT cycle 3
        cyc(); idle(); mem_access = 1; #1;
        chk("acc_req", 32'(ctrl()), 32'(C_REQ));
        cyc(); #1;
        chk("acc_w1", 32'(ctrl()), 32'(C_WAIT));
        cyc(); #1;
        chk("acc_w2", 32'(ctrl()), 32'(C_WAIT));
        cyc(); dmem_ack = 1; #1;
        chk("acc_ack", 32'(ctrl()), 32'(C_ADV));
        cyc(); idle(); #1;
        chk("acc_done", 32'(ctrl()), 32'(C_RUN));
        chk("acc_stall", 32'(stall_cnt), 5);
        chk("acc_tmo", 32'(mem_timeout), 0);

        // no ack: timeout on MEM_WAIT cycle 4
        cyc(); mem_access = 1; #1;
        chk("to_req", 32'(ctrl()), 32'(C_REQ));
        for (int i = 1; i <= 3; i++) begin
            cyc(); #1;
            chk("to_wait", 32'(ctrl()), 32'(C_WAIT));
        end
        cyc(); #1;
        chk("to_w4", 32'(ctrl()), 32'(C_ADV));
        chk("to_w4_tmo", 32'(mem_timeout), 0);
        cyc(); idle(); #1;
        chk("to_run", 32'(ctrl()), 32'(C_RUN));
        chk("to_tmo", 32'(mem_timeout), 1);
        chk("to_stall", 32'(stall_cnt), 9);
        cyc(); #1;
        chk("to_sticky", 32'(mem_timeout), 1);

        // back-to-back accesses
        cyc(); mem_access = 1; #1;
        chk("b2b_req1", 32'(ctrl()), 32'(C_REQ));
        cyc(); dmem_ack = 1; #1;
        chk("b2b_ack1", 32'(ctrl()), 32'(C_ADV));
        cyc(); dmem_ack = 0; #1;
        chk("b2b_req2", 32'(ctrl()), 32'(C_REQ));

        // clear during MEM_WAIT
        cyc(); #1;
        chk("clr_wait", 32'(ctrl()), 32'(C_WAIT));
        cyc(); clr = 1; #1;
        chk("clr_ctrl", 32'(ctrl()), 32'(C_RST));
        cyc(); clr = 0; idle(); #1;
        chk("clr_ctrl2", 32'(ctrl()), 32'(C_RUN));
        chk("clr_stall", 32'(stall_cnt), 0);
        chk("clr_flush", 32'(flush_cnt), 0);
        chk("clr_tmo", 32'(mem_timeout), 0);

        // saturation after 20 stall cycles
        for (int i = 0; i < 20; i++) begin
            cyc(); ex_mem_to_reg = 1; ex_write_reg = 9; id_rs = 9;
        end
        cyc(); idle(); #1;
        chk("sat_stall", 32'(stall_cnt), 15);
        chk("sat_ctrl", 32'(ctrl()), 32'(C_RUN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the five-stage pipeline. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and selects the next-PC source.
- Load-use hazards: detected in ID against EX; resolved with a one-cycle stall.
- Branch/jump redirects: resolved in MEM; younger stages are flushed.
- Data-memory accesses: a req/ack handshake runs while the whole pipeline is frozen.
- Saturating stall and flush performance counters.

## Interface
Parameters:
- WAIT_MAX, 16: maximum MEM_WAIT cycles before timeout (legal range 1..255).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- clr  in  1  reset. Synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt.
- ex_mem_to_reg  in  1  the EX instruction is a load.
- ex_write_reg  in  5  destination register of the EX instruction.
- mem_branch_taken  in  1  BranchEq & zero of the MEM instruction.
- mem_jump  in  1  the MEM instruction is a jump.
- mem_access  in  1  the MEM instruction is a load or store.
- dmem_ack  in  1  data memory has completed the access.
- dmem_req  out  1  request pulse to data memory.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous zeroing of the register. Flush overrides enable.
- pc_sel  out  2  next-PC source: 00 = pc+4, 01 = pcBranch, 10 = jump target.
- busy  out  1  state != RUN.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.
- flush_cnt  out  CNT_W  saturating count of redirect cycles.

## Operation
States: RUN = 0, MEM_WAIT = 1 (1-bit state register). Control outputs are combinational from state and inputs. Default: all enables 1, all flushes 0, pc_sel 00, dmem_req 0.

Load-use condition (lu):
- ex_mem_to_reg & ex_write_reg != 0 & (ex_write_reg == id_rs | (id_uses_rt & ex_write_reg == id_rt)).

Per-cycle priority in RUN:
1. mem_access → freeze:
   - dmem_req = 1.
   - pc_en = ifid_en = idex_en = exmem_en = 0.
   - memwb_flush = 1.
   - Next state MEM_WAIT; wait_cnt ← 1.
2. Otherwise mem_jump | mem_branch_taken → redirect:
   - pc_sel = 10 if mem_jump, else 01 (jump wins if both are set).
   - ifid_flush = idex_flush = exmem_flush = 1.
   - lu is ignored, because the hazarding instruction is being flushed.
3. Otherwise lu → stall:
   - pc_en = ifid_en = 0; idex_flush = 1 (bubble).
4. Otherwise: defaults.

MEM_WAIT:
- dmem_ack = 0 and wait_cnt < WAIT_MAX:
  - Freeze outputs as in RUN rule 1, except dmem_req = 0.
  - wait_cnt increments.
- dmem_ack = 1:
  - Enables 1, flushes 0; the pipeline advances this cycle.
  - Next state RUN.
- dmem_ack = 0 and wait_cnt == WAIT_MAX:
  - mem_timeout ← 1 (sticky until clr).
  - Advance as if acked; next state RUN.
- Redirect and lu are not evaluated in MEM_WAIT. They are evaluated on the first RUN cycle.
- dmem_ack while in RUN is ignored.

Counters:
- stall_cnt += 1 on every cycle with pc_en = 0.
- flush_cnt += 1 on every redirect cycle.
- Both hold at 2^CNT_W − 1.

## Timing
- Reset:
  - While clr = 1, outputs are: all enables 0, all flushes 1, pc_sel 00, dmem_req 0, busy 0.
  - On the clk edge with clr = 1: state ← RUN, wait_cnt ← 0, stall_cnt ← 0, flush_cnt ← 0, mem_timeout ← 0.
  - clr in MEM_WAIT aborts the access; no dmem_req is issued in the reset cycle.
- Load-use stall: exactly 1 cycle. The consumer re-evaluates next cycle with a bubble in EX, so lu = 0.
- Redirect: 1 cycle. The PC loads the target at the edge ending that cycle.
- Memory access: minimum 2 cycles (request cycle plus ack cycle); dmem_req is a single-cycle pulse per access.
  - Ack in the first MEM_WAIT cycle → 2 frozen/advance cycles total.
  - Back-to-back accesses issue a new request on the first RUN cycle.
- Timeout: fires on MEM_WAIT cycle WAIT_MAX; the pipeline advances on that same cycle.

## Test plan
- Reset then idle, all inputs 0 → pc_en = ifid_en = idex_en = exmem_en = 1, flushes 0, pc_sel = 00, counters 0.
- ex_mem_to_reg = 1, ex_write_reg = 5, id_rs = 5 for one cycle → one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; stall_cnt = 1. Same case with ex_write_reg = 0 → no stall.
- mem_branch_taken = 1 together with a load-use hit → pc_sel = 01, ifid/idex/exmem_flush = 1, pc_en = 1, no stall; flush_cnt = 1. With mem_jump also set → pc_sel = 10.
- mem_access = 1, dmem_ack after 3 MEM_WAIT cycles → dmem_req high for exactly 1 cycle; busy high for 3 cycles (MEM_WAIT entry through ack cycle); frozen for 3 cycles then advance on the ack cycle; stall_cnt = 3.
- WAIT_MAX = 4, ack never arrives → mem_timeout rises on MEM_WAIT cycle 4, the pipeline advances, state returns to RUN, and mem_timeout stays 1 until clr.
- clr asserted mid-MEM_WAIT → next cycle: state RUN, busy 0, counters 0, mem_timeout 0.
- CNT_W = 4, 20 load-use stalls → stall_cnt saturates at 15.
